axi_write_arbiter: RTL and testbench
====================================

# axi_write_arbiter

Two-master to one-slave AXI write-channel arbiter, placed between the bus masters (CPU data port M0, DMA M1) and a single slave write port. It serialises complete write transactions (AW, then W burst, then B) using round-robin grant. It extends the 4-bit master ID to the 8-bit slave ID by prepending a master tag, and flags burst-length violations.

## Interface
- Parameters: none. Widths come from `AXI_define.svh`: `AXI_ID_BITS`=4, `AXI_IDS_BITS`=8, `AXI_ADDR_BITS`=32, `AXI_LEN_BITS`=4, `AXI_SIZE_BITS`=3, `AXI_DATA_BITS`=32, `AXI_STRB_BITS`=4.
- Clock and reset: one clock `ACLK`; reset `ARESETn` is asynchronous and active-high (despite the name, 1 = reset).
- ACLK  in  1  clock.
- ARESETn  in  1  asynchronous active-high reset.
- AWID_Mx  in  4  (x=0,1) master write address channel.
  - Companions: AWADDR_Mx in 32, AWLEN_Mx in 4, AWSIZE_Mx in 3, AWBURST_Mx in 2, AWVALID_Mx in 1, AWREADY_Mx out 1.
- WDATA_Mx  in  32  master write data channel.
  - Companions: WSTRB_Mx in 4, WLAST_Mx in 1, WVALID_Mx in 1, WREADY_Mx out 1.
- BID_Mx  out  4  master write response channel.
  - Companions: BRESP_Mx out 2, BVALID_Mx out 1, BREADY_Mx in 1.
- AWID_S  out  8  slave-side write address channel.
  - Companions: AWADDR_S out 32, AWLEN_S out 4, AWSIZE_S out 3, AWBURST_S out 2, AWVALID_S out 1, AWREADY_S in 1.
- WDATA_S  out  32  slave-side write data channel.
  - Companions: WSTRB_S out 4, WLAST_S out 1, WVALID_S out 1, WREADY_S in 1.
- BID_S  in  8  slave-side write response channel.
  - Companions: BRESP_S in 2, BVALID_S in 1, BREADY_S out 1.
- busy  out  1  high whenever state != IDLE.
- grant_m1  out  1  registered owner: 0 = M0, 1 = M1.
- wlast_err  out  1  one-cycle pulse on a burst-length violation.

## Operation
- FSM states: IDLE, ADDR, DATA, RESP.
- IDLE:
  - All slave VALIDs and all master READYs are 0.
  - If any AWVALID_Mx is set, register the grant and go to ADDR.
  - Both requesting: the master not granted last wins (round-robin).
  - Only one requesting: that master wins.
- ADDR:
  - Granted master's AW fields pass to the slave combinationally.
  - AWID_S = {tag, AWID_Mg}; tag is 4'b0001 for M0, 4'b0010 for M1.
  - AWVALID_S = AWVALID_Mg; AWREADY_Mg = AWREADY_S.
  - On AW handshake: latch AWLEN into len_reg, clear beat_cnt, go to DATA.
- DATA:
  - Granted master's W fields pass through; WREADY_Mg = WREADY_S.
  - beat_cnt increments on each W handshake.
  - On a handshake with WLAST: go to RESP.
  - wlast_err pulses on either violation:
    - WLAST handshake with beat_cnt != len_reg (FSM still goes to RESP);
    - non-last handshake with beat_cnt == len_reg (FSM stays in DATA).
- RESP:
  - BVALID_Mg = BVALID_S; BREADY_S = BREADY_Mg.
  - BID_Mg = BID_S[3:0]; BRESP_Mg = BRESP_S.
  - BID_S[7:4] is not checked; the response always routes to the registered grant.
  - On B handshake: update last-grant to the current owner, go to IDLE.
- Non-granted master always sees AWREADY=0, WREADY=0, BVALID=0.
- All non-valid data outputs are driven 0 when not selected.
- Arithmetic: beat_cnt is 4 bits, so len 15 gives 16 beats with no wrap ambiguity.
  - If beat_cnt would exceed 15 (missing WLAST), it saturates at 15 and wlast_err pulses on every further beat.

## Timing
- Reset: state=IDLE, grant_m1=0, last-grant=M1 (so M0 wins the first tie), len_reg=0, beat_cnt=0.
  - All VALID/READY outputs, busy and wlast_err are 0.
- Arbitration latency is 1 cycle: AWVALID_Mx rises in cycle n, AWVALID_S is visible in cycle n+1.
- AW, W and B paths have zero-cycle combinational pass-through within their state.
- Minimum transaction length: 1 (IDLE) + 1 (AW) + beats + 1 (B) cycles.
  - Back-to-back transactions have one IDLE cycle between them.
- If AWVALID_Mg drops in ADDR (protocol violation), the FSM stays in ADDR; no re-arbitration.
- Reset asserted mid-transaction: outputs go to their reset values immediately (asynchronous); the in-flight burst is abandoned.

## Structure
- Package axi_wr_arb_pkg:
  - state enum (IDLE/ADDR/DATA/RESP);
  - tag constants TAG_M0 = 4'b0001, TAG_M1 = 4'b0010.
- Sub-module rr_arb2: 2-request round-robin picker.
  - Inputs: req[1:0], last.
  - Outputs: gnt, any.
  - Purely combinational; the last-grant register lives in the top level.

## Test plan
- Single M0 write, AWLEN=0, AWID=4'h3 -> AWID_S=8'h13 one cycle after AWVALID_M0; one W beat; BID_M0=4'h3; BVALID_M1 stays 0.
- M0 and M1 assert AWVALID in the same cycle after reset -> M0 served first, M1 served next; a repeated tie then grants M0 again (alternation).
- M1 burst of AWLEN=3 while M0 requests mid-burst -> M0 sees AWREADY_M0=0 until M1's B handshake completes; M0's AW reaches the slave exactly 2 cycles after that handshake.
- Slave holds WREADY_S=0 for 3 cycles, and BREADY_M1=0 for 2 cycles -> no beat lost, beat_cnt stable, state held in DATA and RESP respectively.
- AWLEN=2 with WLAST on beat 2 -> wlast_err pulses once and the FSM moves to RESP. Separately, AWLEN=1 with no WLAST on beat 2 -> wlast_err pulses and the FSM stays in DATA.
- ARESETn asserted during DATA -> all VALID/READY outputs drop to 0 the same cycle; after release, the next tie grants M0.

Source files
------------

// File: rtl/axi_wr_arb_pkg.sv
// Shared types and constants for the two-master AXI write arbiter.
// Bus widths live here so every file in the slice agrees on them.
package axi_wr_arb_pkg;

  localparam int AXI_ID_BITS   = 4;
  localparam int AXI_IDS_BITS  = 8;
  localparam int AXI_ADDR_BITS = 32;
  localparam int AXI_LEN_BITS  = 4;
  localparam int AXI_SIZE_BITS = 3;
  localparam int AXI_DATA_BITS = 32;
  localparam int AXI_STRB_BITS = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    RESP = 2'd3
  } state_e;

  // Upper nibble of the slave-side ID identifies which master issued the write.
  localparam logic [3:0] TAG_M0 = 4'b0001;
  localparam logic [3:0] TAG_M1 = 4'b0010;

endpackage

// File: rtl/axi_write_arbiter_rr_arb2.sv
// Two-request round-robin picker; the last-grant state is held by the caller.
// gnt = 1 selects requester 1.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       gnt,
  output logic       any
);

  // On a tie the requester that was not served last wins.
  always_comb begin
    any = |req;
    gnt = (req == 2'b11) ? ~last : req[1];
  end

endmodule

// File: rtl/axi_write_arbiter.sv
// Serialises whole AXI write transactions (AW, W burst, B) from two masters
// onto one slave port, tagging IDs by master and flagging burst-length errors.
module axi_write_arbiter
  import axi_wr_arb_pkg::*;
(
  input  logic                     ACLK,
  input  logic                     ARESETn,
  // Master 0 (CPU data port)
  input  logic [AXI_ID_BITS-1:0]   AWID_M0,
  input  logic [AXI_ADDR_BITS-1:0] AWADDR_M0,
  input  logic [AXI_LEN_BITS-1:0]  AWLEN_M0,
  input  logic [AXI_SIZE_BITS-1:0] AWSIZE_M0,
  input  logic [1:0]               AWBURST_M0,
  input  logic                     AWVALID_M0,
  output logic                     AWREADY_M0,
  input  logic [AXI_DATA_BITS-1:0] WDATA_M0,
  input  logic [AXI_STRB_BITS-1:0] WSTRB_M0,
  input  logic                     WLAST_M0,
  input  logic                     WVALID_M0,
  output logic                     WREADY_M0,
  output logic [AXI_ID_BITS-1:0]   BID_M0,
  output logic [1:0]               BRESP_M0,
  output logic                     BVALID_M0,
  input  logic                     BREADY_M0,
  // Master 1 (DMA)
  input  logic [AXI_ID_BITS-1:0]   AWID_M1,
  input  logic [AXI_ADDR_BITS-1:0] AWADDR_M1,
  input  logic [AXI_LEN_BITS-1:0]  AWLEN_M1,
  input  logic [AXI_SIZE_BITS-1:0] AWSIZE_M1,
  input  logic [1:0]               AWBURST_M1,
  input  logic                     AWVALID_M1,
  output logic                     AWREADY_M1,
  input  logic [AXI_DATA_BITS-1:0] WDATA_M1,
  input  logic [AXI_STRB_BITS-1:0] WSTRB_M1,
  input  logic                     WLAST_M1,
  input  logic                     WVALID_M1,
  output logic                     WREADY_M1,
  output logic [AXI_ID_BITS-1:0]   BID_M1,
  output logic [1:0]               BRESP_M1,
  output logic                     BVALID_M1,
  input  logic                     BREADY_M1,
  // Slave port
  output logic [AXI_IDS_BITS-1:0]  AWID_S,
  output logic [AXI_ADDR_BITS-1:0] AWADDR_S,
  output logic [AXI_LEN_BITS-1:0]  AWLEN_S,
  output logic [AXI_SIZE_BITS-1:0] AWSIZE_S,
  output logic [1:0]               AWBURST_S,
  output logic                     AWVALID_S,
  input  logic                     AWREADY_S,
  output logic [AXI_DATA_BITS-1:0] WDATA_S,
  output logic [AXI_STRB_BITS-1:0] WSTRB_S,
  output logic                     WLAST_S,
  output logic                     WVALID_S,
  input  logic                     WREADY_S,
  input  logic [AXI_IDS_BITS-1:0]  BID_S,
  input  logic [1:0]               BRESP_S,
  input  logic                     BVALID_S,
  output logic                     BREADY_S,
  // Status
  output logic                     busy,
  output logic                     grant_m1,
  output logic                     wlast_err
);

  state_e                    state_q;
  logic                      grant_q;
  logic                      last_q;
  logic [AXI_LEN_BITS-1:0]   len_q;
  logic [AXI_LEN_BITS-1:0]   beat_cnt_q;
  logic                      wlast_err_q;

  logic                      arb_gnt;
  logic                      arb_any;

  logic                      awvalid_g;
  logic [AXI_LEN_BITS-1:0]   awlen_g;
  logic                      wvalid_g;
  logic                      wlast_g;
  logic                      bready_g;
  logic                      aw_hs;
  logic                      w_hs;
  logic                      b_hs;

  // The routing tag travels back in BID_S[7:4] but routing uses the registered grant.
  logic                      unused_bid_hi;
  assign unused_bid_hi = ^BID_S[7:4];

  rr_arb2 u_rr_arb2 (
    .req  ({AWVALID_M1, AWVALID_M0}),
    .last (last_q),
    .gnt  (arb_gnt),
    .any  (arb_any)
  );

  assign awvalid_g = grant_q ? AWVALID_M1 : AWVALID_M0;
  assign awlen_g   = grant_q ? AWLEN_M1   : AWLEN_M0;
  assign wvalid_g  = grant_q ? WVALID_M1  : WVALID_M0;
  assign wlast_g   = grant_q ? WLAST_M1   : WLAST_M0;
  assign bready_g  = grant_q ? BREADY_M1  : BREADY_M0;

  assign aw_hs = (state_q == ADDR) && awvalid_g && AWREADY_S;
  assign w_hs  = (state_q == DATA) && wvalid_g  && WREADY_S;
  assign b_hs  = (state_q == RESP) && BVALID_S  && bready_g;

  assign busy      = (state_q != IDLE);
  assign grant_m1  = grant_q;
  assign wlast_err = wlast_err_q;

  always_ff @(posedge ACLK or posedge ARESETn) begin
    if (ARESETn) begin
      state_q     <= IDLE;
      grant_q     <= 1'b0;
      last_q      <= 1'b1;
      len_q       <= '0;
      beat_cnt_q  <= '0;
      wlast_err_q <= 1'b0;
    end else begin
      wlast_err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (arb_any) begin
            grant_q <= arb_gnt;
            state_q <= ADDR;
          end
        end
        ADDR: begin
          if (aw_hs) begin
            len_q      <= awlen_g;
            beat_cnt_q <= '0;
            state_q    <= DATA;
          end
        end
        DATA: begin
          if (w_hs) begin
            // Saturate so a burst missing WLAST keeps erroring instead of wrapping.
            if (beat_cnt_q != 4'hF) begin
              beat_cnt_q <= beat_cnt_q + 4'd1;
            end
            if (wlast_g) begin
              wlast_err_q <= (beat_cnt_q != len_q);
              state_q     <= RESP;
            end else begin
              wlast_err_q <= (beat_cnt_q >= len_q);
            end
          end
        end
        RESP: begin
          if (b_hs) begin
            last_q  <= grant_q;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    AWID_S     = '0;
    AWADDR_S   = '0;
    AWLEN_S    = '0;
    AWSIZE_S   = '0;
    AWBURST_S  = '0;
    AWVALID_S  = 1'b0;
    WDATA_S    = '0;
    WSTRB_S    = '0;
    WLAST_S    = 1'b0;
    WVALID_S   = 1'b0;
    BREADY_S   = 1'b0;
    AWREADY_M0 = 1'b0;
    AWREADY_M1 = 1'b0;
    WREADY_M0  = 1'b0;
    WREADY_M1  = 1'b0;
    BID_M0     = '0;
    BID_M1     = '0;
    BRESP_M0   = '0;
    BRESP_M1   = '0;
    BVALID_M0  = 1'b0;
    BVALID_M1  = 1'b0;
    case (state_q)
      ADDR: begin
        AWID_S    = grant_q ? {TAG_M1, AWID_M1} : {TAG_M0, AWID_M0};
        AWADDR_S  = grant_q ? AWADDR_M1  : AWADDR_M0;
        AWLEN_S   = awlen_g;
        AWSIZE_S  = grant_q ? AWSIZE_M1  : AWSIZE_M0;
        AWBURST_S = grant_q ? AWBURST_M1 : AWBURST_M0;
        AWVALID_S = awvalid_g;
        if (grant_q) AWREADY_M1 = AWREADY_S;
        else         AWREADY_M0 = AWREADY_S;
      end
      DATA: begin
        WDATA_S  = grant_q ? WDATA_M1 : WDATA_M0;
        WSTRB_S  = grant_q ? WSTRB_M1 : WSTRB_M0;
        WLAST_S  = wlast_g;
        WVALID_S = wvalid_g;
        if (grant_q) WREADY_M1 = WREADY_S;
        else         WREADY_M0 = WREADY_S;
      end
      RESP: begin
        BREADY_S = bready_g;
        if (grant_q) begin
          BVALID_M1 = BVALID_S;
          BID_M1    = BID_S[3:0];
          BRESP_M1  = BRESP_S;
        end else begin
          BVALID_M0 = BVALID_S;
          BID_M0    = BID_S[3:0];
          BRESP_M0  = BRESP_S;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_axi_write_arbiter.sv
// Directed self-checking bench for axi_write_arbiter: a table of single-master
// transactions plus hand sequences for ties, stalls and mid-burst reset.
module tb_axi_write_arbiter;

  logic        ACLK;
  logic        ARESETn;
  logic [3:0]  AWID_M0, AWID_M1;
  logic [31:0] AWADDR_M0, AWADDR_M1;
  logic [3:0]  AWLEN_M0, AWLEN_M1;
  logic [2:0]  AWSIZE_M0, AWSIZE_M1;
  logic [1:0]  AWBURST_M0, AWBURST_M1;
  logic        AWVALID_M0, AWVALID_M1;
  logic        AWREADY_M0, AWREADY_M1;
  logic [31:0] WDATA_M0, WDATA_M1;
  logic [3:0]  WSTRB_M0, WSTRB_M1;
  logic        WLAST_M0, WLAST_M1;
  logic        WVALID_M0, WVALID_M1;
  logic        WREADY_M0, WREADY_M1;
  logic [3:0]  BID_M0, BID_M1;
  logic [1:0]  BRESP_M0, BRESP_M1;
  logic        BVALID_M0, BVALID_M1;
  logic        BREADY_M0, BREADY_M1;
  logic [7:0]  AWID_S;
  logic [31:0] AWADDR_S;
  logic [3:0]  AWLEN_S;
  logic [2:0]  AWSIZE_S;
  logic [1:0]  AWBURST_S;
  logic        AWVALID_S, AWREADY_S;
  logic [31:0] WDATA_S;
  logic [3:0]  WSTRB_S;
  logic        WLAST_S, WVALID_S, WREADY_S;
  logic [7:0]  BID_S;
  logic [1:0]  BRESP_S;
  logic        BVALID_S, BREADY_S;
  logic        busy, grant_m1, wlast_err;

  int compared = 0;
  int mismatched = 0;

  axi_write_arbiter dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .AWID_M0(AWID_M0), .AWADDR_M0(AWADDR_M0), .AWLEN_M0(AWLEN_M0), .AWSIZE_M0(AWSIZE_M0),
    .AWBURST_M0(AWBURST_M0), .AWVALID_M0(AWVALID_M0), .AWREADY_M0(AWREADY_M0),
    .WDATA_M0(WDATA_M0), .WSTRB_M0(WSTRB_M0), .WLAST_M0(WLAST_M0), .WVALID_M0(WVALID_M0),
    .WREADY_M0(WREADY_M0), .BID_M0(BID_M0), .BRESP_M0(BRESP_M0), .BVALID_M0(BVALID_M0),
    .BREADY_M0(BREADY_M0),
    .AWID_M1(AWID_M1), .AWADDR_M1(AWADDR_M1), .AWLEN_M1(AWLEN_M1), .AWSIZE_M1(AWSIZE_M1),
    .AWBURST_M1(AWBURST_M1), .AWVALID_M1(AWVALID_M1), .AWREADY_M1(AWREADY_M1),
    .WDATA_M1(WDATA_M1), .WSTRB_M1(WSTRB_M1), .WLAST_M1(WLAST_M1), .WVALID_M1(WVALID_M1),
    .WREADY_M1(WREADY_M1), .BID_M1(BID_M1), .BRESP_M1(BRESP_M1), .BVALID_M1(BVALID_M1),
    .BREADY_M1(BREADY_M1),
    .AWID_S(AWID_S), .AWADDR_S(AWADDR_S), .AWLEN_S(AWLEN_S), .AWSIZE_S(AWSIZE_S),
    .AWBURST_S(AWBURST_S), .AWVALID_S(AWVALID_S), .AWREADY_S(AWREADY_S),
    .WDATA_S(WDATA_S), .WSTRB_S(WSTRB_S), .WLAST_S(WLAST_S), .WVALID_S(WVALID_S),
    .WREADY_S(WREADY_S), .BID_S(BID_S), .BRESP_S(BRESP_S), .BVALID_S(BVALID_S),
    .BREADY_S(BREADY_S),
    .busy(busy), .grant_m1(grant_m1), .wlast_err(wlast_err)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  typedef struct {
    logic       m;
    logic [3:0] id;
    logic [3:0] len;
    int         nBeats;
    logic [1:0] resp;
    logic [3:0] bidHigh;
    logic [7:0] expAwidS;
    int         expErrs;
  } vec_t;

  vec_t vecs[6];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic setAw(input logic m, input logic v, input logic [3:0] id, input logic [3:0] len);
    if (m) begin
      AWVALID_M1 = v; AWID_M1 = id; AWLEN_M1 = len;
      AWADDR_M1 = 32'h4000_0000 + {24'h0, id, 4'h0}; AWSIZE_M1 = 3'd2; AWBURST_M1 = 2'b01;
    end else begin
      AWVALID_M0 = v; AWID_M0 = id; AWLEN_M0 = len;
      AWADDR_M0 = 32'h4000_0000 + {24'h0, id, 4'h0}; AWSIZE_M0 = 3'd2; AWBURST_M0 = 2'b01;
    end
  endtask

  task automatic setW(input logic m, input logic v, input logic [31:0] d, input logic last);
    if (m) begin
      WVALID_M1 = v; WDATA_M1 = d; WLAST_M1 = last; WSTRB_M1 = 4'hF;
    end else begin
      WVALID_M0 = v; WDATA_M0 = d; WLAST_M0 = last; WSTRB_M0 = 4'hF;
    end
  endtask

  // Runs one complete transaction starting from an IDLE negedge; ends at the next IDLE negedge.
  task automatic applyStimulus(input logic m, input logic [3:0] id, input logic [3:0] len,
                               input int nBeats, input logic [1:0] resp, input logic [3:0] bidHigh,
                               input logic [7:0] expAwidS, input int expErrs);
    int errs = 0;
    logic expErr;
    logic [31:0] d;
    setAw(m, 1'b1, id, len);
    AWREADY_S = 1'b1;
    WREADY_S  = 1'b1;
    #1;
    checkOutput("idleAwvalidS", AWVALID_S, 0);
    checkOutput("idleBusy", busy, 0);
    @(negedge ACLK); #1;
    checkOutput("addrGrant", grant_m1, m);
    checkOutput("addrAwvalidS", AWVALID_S, 1);
    checkOutput("addrAwidS", AWID_S, expAwidS);
    checkOutput("addrAwaddrS", AWADDR_S, 32'h4000_0000 + {24'h0, id, 4'h0});
    checkOutput("addrAwlenS", AWLEN_S, len);
    checkOutput("addrAwreadyG", m ? AWREADY_M1 : AWREADY_M0, 1);
    checkOutput("addrAwreadyOther", m ? AWREADY_M0 : AWREADY_M1, 0);
    @(negedge ACLK);
    setAw(m, 1'b0, id, len);
    for (int i = 0; i < nBeats; i++) begin
      d = 32'hC0DE_0000 + {20'h0, id, 8'h0} + i;
      setW(m, 1'b1, d, (i == nBeats - 1));
      #1;
      checkOutput("dataWvalidS", WVALID_S, 1);
      checkOutput("dataWdataS", WDATA_S, d);
      checkOutput("dataWlastS", WLAST_S, (i == nBeats - 1));
      checkOutput("dataWreadyG", m ? WREADY_M1 : WREADY_M0, 1);
      checkOutput("dataWreadyOther", m ? WREADY_M0 : WREADY_M1, 0);
      @(negedge ACLK);
      expErr = (i == nBeats - 1) ? (i != int'(len)) : (i >= int'(len));
      checkOutput("beatWlastErr", wlast_err, expErr);
      if (wlast_err === 1'b1) errs++;
    end
    setW(m, 1'b0, 32'h0, 1'b0);
    BVALID_S = 1'b1;
    BID_S    = {bidHigh, id};
    BRESP_S  = resp;
    if (m) BREADY_M1 = 1'b1; else BREADY_M0 = 1'b1;
    #1;
    checkOutput("respBvalidG", m ? BVALID_M1 : BVALID_M0, 1);
    checkOutput("respBvalidOther", m ? BVALID_M0 : BVALID_M1, 0);
    checkOutput("respBidG", m ? BID_M1 : BID_M0, id);
    checkOutput("respBrespG", m ? BRESP_M1 : BRESP_M0, resp);
    checkOutput("respBreadyS", BREADY_S, 1);
    checkOutput("respWvalidS", WVALID_S, 0);
    @(negedge ACLK);
    BVALID_S = 1'b0;
    BREADY_M0 = 1'b0;
    BREADY_M1 = 1'b0;
    #1;
    checkOutput("doneBusy", busy, 0);
    checkOutput("errCount", errs, expErrs);
  endtask

  initial begin
    vecs[0] = '{m:1'b0, id:4'h3, len:4'd0,  nBeats:1,  resp:2'b00, bidHigh:4'h1, expAwidS:8'h13, expErrs:0};
    vecs[1] = '{m:1'b1, id:4'hA, len:4'd3,  nBeats:4,  resp:2'b10, bidHigh:4'hF, expAwidS:8'h2A, expErrs:0};
    vecs[2] = '{m:1'b0, id:4'h5, len:4'd2,  nBeats:2,  resp:2'b00, bidHigh:4'h1, expAwidS:8'h15, expErrs:1};
    vecs[3] = '{m:1'b1, id:4'h7, len:4'd1,  nBeats:3,  resp:2'b11, bidHigh:4'h2, expAwidS:8'h27, expErrs:2};
    vecs[4] = '{m:1'b0, id:4'hF, len:4'd15, nBeats:16, resp:2'b01, bidHigh:4'h0, expAwidS:8'h1F, expErrs:0};
    vecs[5] = '{m:1'b1, id:4'h0, len:4'd0,  nBeats:2,  resp:2'b00, bidHigh:4'h2, expAwidS:8'h20, expErrs:2};

    ARESETn = 1'b1;
    setAw(1'b0, 1'b0, 4'h0, 4'h0);
    setAw(1'b1, 1'b0, 4'h0, 4'h0);
    setW(1'b0, 1'b0, 32'h0, 1'b0);
    setW(1'b1, 1'b0, 32'h0, 1'b0);
    BREADY_M0 = 1'b0; BREADY_M1 = 1'b0;
    AWREADY_S = 1'b0; WREADY_S = 1'b0;
    BID_S = 8'h0; BRESP_S = 2'b00; BVALID_S = 1'b0;
    repeat (2) @(negedge ACLK);
    #1;
    checkOutput("rstBusy", busy, 0);
    checkOutput("rstGrant", grant_m1, 0);
    checkOutput("rstWlastErr", wlast_err, 0);
    checkOutput("rstAwvalidS", AWVALID_S, 0);
    checkOutput("rstBreadyS", BREADY_S, 0);
    @(negedge ACLK);
    ARESETn = 1'b0;

    // Tie straight after reset: M0, then M1, then a repeated tie goes to M0 again.
    @(negedge ACLK);
    setAw(1'b1, 1'b1, 4'h6, 4'd0);
    applyStimulus(1'b0, 4'h1, 4'd0, 1, 2'b00, 4'h1, 8'h11, 0);
    applyStimulus(1'b1, 4'h6, 4'd0, 1, 2'b00, 4'h2, 8'h26, 0);
    setAw(1'b1, 1'b1, 4'h8, 4'd1);
    applyStimulus(1'b0, 4'h2, 4'd1, 2, 2'b00, 4'h1, 8'h12, 0);
    applyStimulus(1'b1, 4'h8, 4'd1, 2, 2'b00, 4'h2, 8'h28, 0);

    for (int v = 0; v < 6; v++) begin
      applyStimulus(vecs[v].m, vecs[v].id, vecs[v].len, vecs[v].nBeats, vecs[v].resp,
                    vecs[v].bidHigh, vecs[v].expAwidS, vecs[v].expErrs);
    end

    // M1 burst with W and B stalls while M0 waits its turn.
    setAw(1'b1, 1'b1, 4'h9, 4'd3);
    AWREADY_S = 1'b1; WREADY_S = 1'b1;
    @(negedge ACLK); #1;
    checkOutput("stallGrant", grant_m1, 1);
    checkOutput("stallAwidS", AWID_S, 8'h29);
    @(negedge ACLK);
    setAw(1'b1, 1'b0, 4'h9, 4'd3);
    setAw(1'b0, 1'b1, 4'h4, 4'd0);
    for (int i = 0; i < 4; i++) begin
      setW(1'b1, 1'b1, 32'hAB00_0000 + i, (i == 3));
      if (i == 1) begin
        WREADY_S = 1'b0;
        repeat (3) begin
          #1;
          checkOutput("stallWreadyM1", WREADY_M1, 0);
          checkOutput("stallWvalidS", WVALID_S, 1);
          checkOutput("stallAwreadyM0", AWREADY_M0, 0);
          @(negedge ACLK);
          checkOutput("stallNoErr", wlast_err, 0);
        end
        WREADY_S = 1'b1;
      end
      #1;
      checkOutput("stallWdataS", WDATA_S, 32'hAB00_0000 + i);
      checkOutput("stallBeatReady", WREADY_M1, 1);
      checkOutput("stallAwreadyM0", AWREADY_M0, 0);
      @(negedge ACLK);
      checkOutput("stallBeatErr", wlast_err, 0);
    end
    setW(1'b1, 1'b0, 32'h0, 1'b0);
    BVALID_S = 1'b1; BID_S = 8'h29; BRESP_S = 2'b00; BREADY_M1 = 1'b0;
    repeat (2) begin
      #1;
      checkOutput("bstallBvalidM1", BVALID_M1, 1);
      checkOutput("bstallBreadyS", BREADY_S, 0);
      checkOutput("bstallAwreadyM0", AWREADY_M0, 0);
      checkOutput("bstallBusy", busy, 1);
      @(negedge ACLK);
    end
    BREADY_M1 = 1'b1;
    #1;
    checkOutput("bstallBreadyS", BREADY_S, 1);
    @(negedge ACLK);
    BVALID_S = 1'b0; BREADY_M1 = 1'b0;
    #1;
    checkOutput("handoffIdle", AWVALID_S, 0);
    checkOutput("handoffAwreadyM0", AWREADY_M0, 0);
    @(negedge ACLK); #1;
    checkOutput("handoffAwvalidS", AWVALID_S, 1);
    checkOutput("handoffAwidS", AWID_S, 8'h14);
    checkOutput("handoffGrant", grant_m1, 0);
    @(negedge ACLK);
    setAw(1'b0, 1'b0, 4'h4, 4'd0);
    setW(1'b0, 1'b1, 32'h5555_0000, 1'b1);
    #1;
    checkOutput("handoffWreadyM0", WREADY_M0, 1);
    @(negedge ACLK);
    setW(1'b0, 1'b0, 32'h0, 1'b0);
    BVALID_S = 1'b1; BID_S = 8'h14; BREADY_M0 = 1'b1;
    #1;
    checkOutput("handoffBidM0", BID_M0, 4'h4);
    @(negedge ACLK);
    BVALID_S = 1'b0; BREADY_M0 = 1'b0;

    // Reset in the middle of an M1 burst; last grant was M0, reset must restore M0 priority.
    setAw(1'b1, 1'b1, 4'hB, 4'd3);
    @(negedge ACLK);
    @(negedge ACLK);
    setAw(1'b1, 1'b0, 4'hB, 4'd3);
    setW(1'b1, 1'b1, 32'h7777_0000, 1'b0);
    #1;
    checkOutput("preRstWreadyM1", WREADY_M1, 1);
    ARESETn = 1'b1;
    #1;
    checkOutput("midRstWreadyM1", WREADY_M1, 0);
    checkOutput("midRstWvalidS", WVALID_S, 0);
    checkOutput("midRstBusy", busy, 0);
    checkOutput("midRstGrant", grant_m1, 0);
    @(negedge ACLK);
    ARESETn = 1'b0;
    setW(1'b1, 1'b0, 32'h0, 1'b0);
    setAw(1'b1, 1'b1, 4'hC, 4'd0);
    applyStimulus(1'b0, 4'hD, 4'd0, 1, 2'b00, 4'h1, 8'h1D, 0);
    applyStimulus(1'b1, 4'hC, 4'd0, 1, 2'b00, 4'h2, 8'h2C, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
